bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/serial_pkg.sv | 14 +
 rtl/bit_timer.sv | 31 +++
 rtl/bit_serializer.sv | 109 ++++++++++
 tb/tb_bit_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and default sizing.
package serial_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DIV        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle timer: reloads to DIV on load, counts down to zero without wrapping,
// and flags the last cycle of the current bit with a one-cycle bit_end.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  output logic bit_end
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIV);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  // Last cycle of the bit; the FSM reloads on the following edge.
  assign bit_end = (cnt_q == ONE);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: start bit (0), DATA_WIDTH bits LSB first, stop bit (1),
// each bit held DIV cycles on a registered, idle-high line.
//
// state | meaning
// IDLE  | line high, in_ready asserted, waiting for a word
// START | start bit (0) on the line
// DATA  | payload bits, LSB first
// STOP  | stop bit (1) on the line
module bit_serializer
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DIV        = DEFAULT_DIV
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out0,
  output logic                  busy
);

  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  out_d;
  logic                  load;
  logic                  bit_end;

  bit_timer #(.DIV(DIV)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .bit_end (bit_end)
  );

  assign in_ready = reset_n && (state_q == IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      out0    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      out0    <= out_d;
      busy    <= (state_d != IDLE);
    end
  end

  // idx_q counts payload bits already placed on the line.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    out_d   = out0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = START;
          shift_d = in0;
          out_d   = 1'b0;
          load    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          out_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = IDX_ONE;
          load    = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          load = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            out_d   = 1'b1;
            idx_d   = '0;
          end else begin
            out_d   = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_ONE;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          out_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: a frame-level model queues expected words on
// acceptance; a line monitor pops one per start bit and checks every cycle of the frame.
module tb_bit_serializer;

  localparam int DW    = 8;
  localparam int DIV   = 4;
  localparam int FRAME = (DW + 2) * DIV;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, in_valid, in_ready, out0, busy;
  logic [DW-1:0] in0;
  logic          v1, rdy1, o1, b1;
  logic [DW-1:0] i1;

  bit_serializer #(.DATA_WIDTH(DW), .DIV(DIV)) dut (
    .clock(clock), .reset_n(reset_n), .in0(in0), .in_valid(in_valid),
    .in_ready(in_ready), .out0(out0), .busy(busy)
  );

  bit_serializer #(.DATA_WIDTH(DW), .DIV(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in0(i1), .in_valid(v1),
    .in_ready(rdy1), .out0(o1), .busy(b1)
  );

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, ncyc, act, exp);
    end
  endtask

  // Bit k of the frame on the wire: start, payload LSB first, stop.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    return 1'b1;
  endfunction

  typedef struct {
    logic [DW-1:0] word;
    int            acc;
  } item_t;

  item_t q[$];
  int    rem = 0;
  bit    rst_seen = 1'b0;

  // Reference model: a word is taken whenever the line is free and in_valid is high;
  // the line is then occupied for FRAME cycles. Reset discards everything.
  initial forever begin
    @(posedge clock);
    rst_seen = !reset_n;
    if (!reset_n) begin
      rem = 0;
      q.delete();
    end else if (rem == 0) begin
      if (in_valid) begin
        q.push_back('{word: in0, acc: ncyc});
        rem = FRAME;
      end
    end else begin
      rem = rem - 1;
    end
    ncyc = ncyc + 1;
  end

  bit    in_frame = 1'b0;
  int    pos = 0;
  item_t cur;

  initial forever begin
    @(negedge clock);
    if (ncyc > 0) begin
      check("in_ready", in_ready, reset_n && (rem == 0));
      check("busy", busy, rem != 0);
      if (rst_seen) in_frame = 1'b0;
      if (in_frame) begin
        check("frame_bit", out0, frame_bit(cur.word, pos / DIV));
        pos++;
        if (pos == FRAME) in_frame = 1'b0;
      end else if (out0 == 1'b0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame cycle %0d: got start bit expected idle high", ncyc);
        end else begin
          cur = q.pop_front();
          check("start_time", ncyc, cur.acc + 1);
          pos      = 1;
          in_frame = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in0      = '0;
    v1       = 1'b0;
    i1       = '0;
    tick(3);
    reset_n = 1'b1;
    tick(100);

    // DIV=1 instance: one bit per cycle
    v1 = 1'b1;
    i1 = 8'h01;
    tick(1);
    v1 = 1'b0;
    for (int k = 0; k < DW + 2; k++) begin
      @(negedge clock);
      check("div1_bit", o1, frame_bit(8'h01, k));
      check("div1_busy", b1, 1'b1);
    end
    @(negedge clock);
    check("div1_idle_line", o1, 1'b1);
    check("div1_idle_busy", b1, 1'b0);
    check("div1_ready", rdy1, 1'b1);
    tick(1);

    // single frame
    in_valid = 1'b1;
    in0      = 8'hA5;
    tick(1);
    in_valid = 1'b0;
    tick(45);

    // back-to-back with in_valid held high
    in_valid = 1'b1;
    in0      = 8'h00;
    tick(1);
    in0 = 8'hFF;
    tick(FRAME + 1);
    in_valid = 1'b0;
    tick(45);

    // inputs toggled during a frame must be ignored
    in_valid = 1'b1;
    in0      = 8'h5A;
    tick(1);
    repeat (30) begin
      in_valid = 1'($urandom_range(0, 1));
      in0      = DW'($urandom);
      tick(1);
    end
    in_valid = 1'b0;
    tick(15);

    // reset during data bit 3
    in_valid = 1'b1;
    in0      = 8'h3C;
    tick(1);
    in_valid = 1'b0;
    tick(17);
    reset_n = 1'b0;
    tick(1);
    @(negedge clock);
    check("rst_out0", out0, 1'b1);
    check("rst_busy", busy, 1'b0);
    tick(1);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in0      = 8'h81;
    tick(1);
    in_valid = 1'b0;
    tick(45);

    // random traffic with occasional resets
    repeat (400) begin
      in0      = DW'($urandom);
      in_valid = ($urandom_range(0, 3) == 0);
      reset_n  = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick(50);

    check("queue_empty", q.size(), 0);
    check("monitor_idle", in_frame, 1'b0);
    check("final_line", out0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
